// File: rtl/imem_fetch_unit.sv
// Instruction-fetch reader between the PC register and a variable-latency instruction memory.
// One fetch in flight at a time; the returned word and its PC are held for decode until accepted.
module imem_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              flush,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err,
    output logic [2:0]        fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // pc side: pc_valid/pc_ready. Decode side: instr_valid/instr_ready. Memory side: imem_req
    // is held with a stable imem_addr until the single-cycle imem_ack pulse.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic pc_fire;
    logic pc_aligned;
    logic timeout_hit;

    assign pc_fire     = pc_valid & pc_ready;
    assign pc_aligned  = (pc_in[1:0] == 2'b00);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack always wins over the timeout: a word arriving on the last allowed cycle is kept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pc_fire) begin
                    state_d = pc_aligned ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = flush ? S_IDLE : S_HOLD;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_HOLD: begin
                if (flush || instr_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Gating pc_ready with resetn keeps it low for the whole reset pulse.
    always_comb begin
        fetch_err   = (state_q == S_ERR);
        pc_ready    = resetn && (state_q == S_IDLE) && !fetch_err;
        imem_req    = (state_q == S_WAIT) || (state_q == S_DRAIN);
        instr_valid = (state_q == S_HOLD);
        fsm_state   = state_q;
    end

    always_comb begin
        addr_d  = addr_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pc_fire && pc_aligned) begin
                    addr_d = pc_in;
                    pc_d   = pc_in;
                    cnt_d  = '0;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (state_q == S_WAIT && imem_ack && !flush) begin
                    instr_d = imem_rdata;
                end
                if (!imem_ack && !timeout_hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr = addr_q;
    assign instr_pc  = pc_q;
    assign instr_out = instr_q;

endmodule
